pc_fetch_unit: RTL and testbench

- Program counter register and fetch sequencer at the head of the IF stage.
- Drives PCResult to the PC adder and to instruction memory.
- Takes the PC+4 value back from the PC adder as its sequential next-PC.
- Picks the next PC from redirect sources and stalls. Handles the instruction-memory request/acknowledge handshake and flags misaligned redirect targets.

---
 rtl/pc_fetch_unit_pkg.sv | 17 +
 rtl/pc_fetch_unit_next_sel.sv | 43 ++++
 rtl/pc_fetch_unit.sv | 83 ++++++++
 tb/tb_pc_fetch_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// rtl/pc_fetch_unit_pkg.sv - shared state encoding, reset vector and alignment helper for the fetch unit
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [1:0]  WORD_ALIGN_MASK      = 2'b00;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_next_sel.sv
// rtl/pc_fetch_unit_next_sel.sv - next-PC priority mux with misaligned redirect detection
module pc_next_sel
    import pc_fetch_unit_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_add_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        stall_i,
    input  logic        fire_i,
    output logic [31:0] next_pc_o,
    output logic        load_en_o,
    output logic        fault_set_o
);

    // Only the redirect that actually wins is checked; a dropped jump can never fault.
    always_comb begin
        next_pc_o   = pc_i;
        load_en_o   = 1'b0;
        fault_set_o = 1'b0;
        if (branch_taken_i) begin
            if (is_word_aligned(branch_target_i)) begin
                next_pc_o = branch_target_i;
                load_en_o = 1'b1;
            end else begin
                fault_set_o = 1'b1;
            end
        end else if (jump_i && !stall_i) begin
            if (is_word_aligned(jump_target_i)) begin
                next_pc_o = jump_target_i;
                load_en_o = 1'b1;
            end else begin
                fault_set_o = 1'b1;
            end
        end else if (fire_i) begin
            next_pc_o = pc_add_i;
            load_en_o = 1'b1;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter register and IF-stage fetch sequencer
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCAddResult,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        Stall,
    input  logic        ImemAck,
    output logic [31:0] PCResult,
    output logic        ImemReq,
    output logic        FetchValid,
    output logic        MisalignFault
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic         fault_q;
    logic         in_fetch;
    logic         fire;
    logic [31:0]  next_pc;
    logic         load_en;
    logic         fault_set;

    assign in_fetch = (state_q == ST_FETCH);
    assign ImemReq  = in_fetch && !Stall;
    assign fire     = ImemReq && ImemAck;

    // A word returned in a redirect cycle belongs to the squashed path.
    assign FetchValid    = fire && !BranchTaken && !(Jump && !Stall);
    assign PCResult      = pc_q;
    assign MisalignFault = fault_q;

    pc_next_sel u_next_sel (
        .pc_i            (pc_q),
        .pc_add_i        (PCAddResult),
        .branch_taken_i  (BranchTaken),
        .branch_target_i (BranchTarget),
        .jump_i          (Jump),
        .jump_target_i   (JumpTarget),
        .stall_i         (Stall),
        .fire_i          (fire),
        .next_pc_o       (next_pc),
        .load_en_o       (load_en),
        .fault_set_o     (fault_set)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (fault_set) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                    end else if (load_en) begin
                        pc_q <= next_pc;
                    end
                end
                ST_FAULT: begin
                    fault_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_FAULT;
                    fault_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - table-driven directed testbench for pc_fetch_unit
module tb_pc_fetch_unit;

    typedef struct {
        logic        stall;
        logic        ack;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic [31:0] exp_pc;
        logic        exp_req;
        logic        exp_fv;
        logic        exp_fault;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_add;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        stall;
    logic        imem_ack;
    logic [31:0] pc;
    logic        imem_req;
    logic        fetch_valid;
    logic        misalign_fault;

    int tests_run;
    int tests_failed;
    vec_t vecs[$];

    pc_fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
        .Clk           (clk),
        .Reset         (rst_n),
        .PCAddResult   (pc_add),
        .BranchTaken   (branch_taken),
        .BranchTarget  (branch_target),
        .Jump          (jump),
        .JumpTarget    (jump_target),
        .Stall         (stall),
        .ImemAck       (imem_ack),
        .PCResult      (pc),
        .ImemReq       (imem_req),
        .FetchValid    (fetch_valid),
        .MisalignFault (misalign_fault)
    );

    // External PC adder, wrapping naturally at 32 bits.
    assign pc_add = pc + 32'd4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, input logic a, input logic b, input logic [31:0] bta,
                                input logic j, input logic [31:0] jta, input logic [31:0] epc,
                                input logic ereq, input logic efv, input logic eflt);
        vec_t v;
        v.stall = s; v.ack = a; v.br = b; v.bt = bta; v.jmp = j; v.jt = jta;
        v.exp_pc = epc; v.exp_req = ereq; v.exp_fv = efv; v.exp_fault = eflt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        check({tag, " pc"},    pc,                     v.exp_pc);
        check({tag, " req"},   {31'd0, imem_req},      {31'd0, v.exp_req});
        check({tag, " fv"},    {31'd0, fetch_valid},   {31'd0, v.exp_fv});
        check({tag, " fault"}, {31'd0, misalign_fault}, {31'd0, v.exp_fault});
    endtask

    // Called at a falling edge: drive, settle, compare, then advance one cycle.
    task automatic run_vec(input string tag, input vec_t v);
        stall = v.stall; imem_ack = v.ack;
        branch_taken = v.br; branch_target = v.bt;
        jump = v.jmp; jump_target = v.jt;
        #1;
        check_outs(tag, v);
        @(negedge clk);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        stall = 1'b0; imem_ack = 1'b1;
        branch_taken = 1'b0; branch_target = 32'h0;
        jump = 1'b0; jump_target = 32'h0;

        //          st a  br bt            j  jt            pc            rq fv flt
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,   32'h0,        0, 0, 0)); // BOOT
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,   32'h0,        1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,   32'h4,        1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,   32'h8,        1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,   32'hC,        1, 1, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   32'h10,       0, 0, 0)); // stall x3
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   32'h10,       0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   32'h10,       0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,   32'h10,       1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,   32'h14,       1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,   32'h18,       1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,   32'h1C,       1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,   32'h20,       1, 0, 0)); // no ack x2
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,   32'h20,       1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,   32'h20,       1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,   32'h24,       1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,   32'h28,       1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,   32'h2C,       1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 32'h100,      1, 32'h200, 32'h30,       1, 0, 0)); // branch beats jump
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,   32'h100,      1, 1, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0,        1, 32'h300, 32'h104,      0, 0, 0)); // jump under stall
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h300, 32'h104,      1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 32'h400,      0, 32'h0,   32'h300,      0, 0, 0)); // branch under stall
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,   32'h400,      1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0,  32'h404,      1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,   32'hFFFF_FFFC, 1, 1, 0)); // wrap
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,   32'h0,        1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h40,  32'h4,        1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h202, 32'h40,       1, 0, 0)); // misaligned jump
        vecs.push_back(mk(0, 1, 1, 32'h500,      0, 32'h0,   32'h40,       0, 0, 1)); // FAULT ignores all
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h600, 32'h40,       0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,   32'h40,       0, 0, 1));

        @(negedge clk);
        #1;
        check_outs("reset", mk(0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        // Reset out of FAULT, then confirm BOOT ignores a redirect.
        rst_n = 1'b0;
        #1;
        check_outs("fault_rst", mk(0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("boot_redir", mk(0, 1, 1, 32'h80, 0, 32'h0, 32'h0, 0, 0, 0));
        run_vec("to_50",      mk(0, 1, 1, 32'h50, 0, 32'h0, 32'h0, 1, 0, 0));

        // Reset asserted mid-request, away from any clock edge.
        stall = 1'b0; imem_ack = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        #1;
        check_outs("pend50", mk(0, 0, 0, 0, 0, 0, 32'h50, 1, 0, 0));
        #1;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0));
        imem_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("boot_ack", mk(0, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0));
        run_vec("post_rst", mk(0, 1, 0, 32'h0, 0, 32'h0, 32'h0, 1, 1, 0));
        run_vec("post_rst2", mk(0, 1, 0, 32'h0, 0, 32'h0, 32'h4, 1, 1, 0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
